decoded_bit_reorder: RTL and testbench
======================================

DECODED_BIT_REORDER -- requirements
Module: decoded_bit_reorder

Interface
REQ-001 Parameter FRAME_LEN, default 64, is the number of decoded bits per trace-back frame (legal range 2..64).
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 bit_valid  input  1  decoded_bit is present this cycle, driven by the trace-back stage.
REQ-006 decoded_bit  input  1  decoded bit from trace-back, arriving newest-time-step first.
REQ-007 frame_abort  input  1  discard the partially filled write bank.
REQ-008 in_ready  output  1  write bank can accept a bit.
REQ-009 out_valid  output  1  out_bit is valid.
REQ-010 out_ready  input  1  consumer accepts out_bit.
REQ-011 out_bit  output  1  decoded bit, presented in chronological order.
REQ-012 out_last  output  1  out_bit is the final bit of its frame.
REQ-013 overflow  output  1  sticky flag: a bit was dropped.

Function
REQ-014 The block SHALL hold two FRAME_LEN-bit banks (ping-pong); each bank has a state FILLING or FULL.
REQ-015 Write side: wr_bank (1 bit), wr_cnt (6 bits); in_ready = (state[wr_bank] == FILLING).
REQ-016 When bit_valid and in_ready, the block SHALL store decoded_bit at bank[wr_bank][wr_cnt] and increment wr_cnt.
REQ-017 When the accepted bit has wr_cnt == FRAME_LEN-1, state[wr_bank] SHALL become FULL, wr_cnt SHALL wrap to 0, and wr_bank SHALL toggle.
REQ-018 When bit_valid and !in_ready, the bit SHALL be dropped and overflow SHALL set to 1, staying set until reset.
REQ-019 Read side: rd_bank (1 bit), rd_idx (6 bits); out_valid = (state[rd_bank] == FULL).
REQ-020 The first output of a bank SHALL be rd_idx = FRAME_LEN-1 (the last bit written); out_bit = bank[rd_bank][rd_idx] (LIFO reversal).
REQ-021 On out_valid and out_ready, rd_idx SHALL decrement; out_last = out_valid and (rd_idx == 0).
REQ-022 On acceptance with rd_idx == 0, state[rd_bank] SHALL become FILLING, rd_idx SHALL reload to FRAME_LEN-1, and rd_bank SHALL toggle.
REQ-023 While out_valid and !out_ready, out_bit, out_last and rd_idx SHALL hold stable.
REQ-024 Latency: out_valid SHALL rise in the cycle after the edge that accepts the frame's last input bit.
REQ-025 A bank freed by the read side SHALL present in_ready = 1 no earlier than the cycle after the freeing edge.
REQ-026 Simultaneous fill completion of one bank and drain completion of the other in one cycle SHALL both take effect.
REQ-027 frame_abort SHALL reset wr_cnt to 0 and keep wr_bank unchanged; a bit_valid in the same cycle SHALL be ignored.
REQ-028 frame_abort SHALL leave FULL banks and the read side untouched.

Reset
REQ-029 On rst, the block SHALL set:
- both banks FILLING; wr_bank = 0; rd_bank = 0
- wr_cnt = 0; rd_idx = FRAME_LEN-1
- overflow = 0; out_valid = 0; out_last = 0; out_bit = 0; in_ready = 1.
REQ-030 Bank storage contents need not be reset.
REQ-031 Reset mid-frame SHALL discard all buffered bits.
REQ-032 rst SHALL take priority over all other inputs.

Configuration
REQ-033 Macro REORDER_DROP_CNT_EN SHALL control an extra output drop_cnt (8 bits, output).
- Defined: drop_cnt counts each dropped bit, saturates at 255, and is cleared by rst.
- Not defined: the drop_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Scenario: FRAME_LEN=64, out_ready=1, feed bits b0..b63 = index[0] (0,1,0,1,...) -> 64 outputs b63..b0 (1,0,1,0,...), out_last with the 64th output, out_valid rising 1 cycle after b63.
REQ-035 Scenario: 128 bits back-to-back with out_ready=0 -> in_ready low after bit 127; bit 128 is dropped; overflow=1; drop_cnt=1 if enabled.
REQ-036 Scenario: out_ready toggling 1,0,1,0 during drain -> out_bit is held during stall cycles and the sequence is unaltered.
REQ-037 Scenario: 30 bits written, frame_abort, then 64 bits 0xFFFF_FFFF_0000_0000 (LSB first) -> output is exactly the reversed 64 bits; no aborted bits appear.
REQ-038 Scenario: rst pulsed after 40 bits of the second frame while the first frame is draining -> out_valid=0 and in_ready=1 the next cycle, and the next frame is output cleanly.

Source files
------------

// File: rtl/decoded_bit_reorder_if.sv
// Handshake bundle between the trace-back stage, the bit reorder buffer and its consumer.
interface decoded_bit_reorder_if;
  logic bit_valid;
  logic decoded_bit;
  logic frame_abort;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;
  logic overflow;

  modport master (
    output bit_valid, decoded_bit, frame_abort, out_ready,
    input  in_ready, out_valid, out_bit, out_last, overflow
  );

  modport slave (
    input  bit_valid, decoded_bit, frame_abort, out_ready,
    output in_ready, out_valid, out_bit, out_last, overflow
  );
endinterface

// File: rtl/decoded_bit_reorder.sv
// Ping-pong LIFO buffer that turns newest-first trace-back bits into chronological order.
// Optional macro REORDER_DROP_CNT_EN adds a saturating 8-bit drop_cnt output.
module decoded_bit_reorder #(
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  decoded_bit_reorder_if.slave  bus
`ifdef REORDER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } bank_state_e;

  bank_state_e            state_q [2];
  bank_state_e            state_d [2];
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
  logic                   overflow_q, overflow_d;
  logic [1:0][FRAME_LEN-1:0] mem_q;

  logic in_ready_c;
  logic out_valid_c;
  logic wr_fire_c;
  logic rd_fire_c;
  logic drop_c;

  // Handshake status decodes directly from the bank state registers.
  assign in_ready_c  = (state_q[wr_bank_q] == FILLING);
  assign out_valid_c = (state_q[rd_bank_q] == FULL);
  assign wr_fire_c   = bus.bit_valid && in_ready_c && !bus.frame_abort;
  assign rd_fire_c   = out_valid_c && bus.out_ready;
  assign drop_c      = bus.bit_valid && !in_ready_c && !bus.frame_abort;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_bit   = out_valid_c && mem_q[rd_bank_q][rd_idx_q];
  assign bus.out_last  = out_valid_c && (rd_idx_q == '0);
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= FILLING;
      state_q[1] <= FILLING;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_idx_q   <= LAST_IDX;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Write and read never target the same bank: one needs FILLING, the other FULL.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;

    if (bus.frame_abort) begin
      wr_cnt_d = '0;
    end else if (wr_fire_c) begin
      if (wr_cnt_q == LAST_IDX) begin
        state_d[wr_bank_q] = FULL;
        wr_cnt_d           = '0;
        wr_bank_d          = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    if (drop_c) begin
      overflow_d = 1'b1;
    end

    if (rd_fire_c) begin
      if (rd_idx_q == '0) begin
        state_d[rd_bank_q] = FILLING;
        rd_idx_d           = LAST_IDX;
        rd_bank_d          = !rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q - CNT_W'(1);
      end
    end
  end

  // Bank storage is not reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_c) begin
      mem_q[wr_bank_q][wr_cnt_q] <= bus.decoded_bit;
    end
  end

`ifdef REORDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_decoded_bit_reorder.sv
// Scoreboard bench: a frame-level model predicts handshakes and reversed output frames.
module tb_decoded_bit_reorder;

  localparam int FL = 64;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  decoded_bit_reorder_if bus();
`ifdef REORDER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  decoded_bit_reorder #(.FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REORDER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic partial[$];
  int   m_full  = 0;
  int   m_rdpos = 0;
  logic m_ovf   = 1'b0;
  int   m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is reversed as a whole once complete; two frames may wait.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        partial.delete();
        exp_q.delete();
        m_full  = 0;
        m_rdpos = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
      end else begin
        bit rd;
        int full_pre;
        full_pre = m_full;
        rd = (full_pre > 0) && bus.out_ready;
        if (bus.frame_abort) begin
          partial.delete();
        end else if (bus.bit_valid) begin
          if (full_pre < 2) begin
            partial.push_back(bus.decoded_bit);
            if (partial.size() == FL) begin
              for (int i = FL - 1; i >= 0; i--) begin
                exp_t e;
                e.b    = partial[i];
                e.last = (i == 0);
                exp_q.push_back(e);
              end
              partial.delete();
              m_full++;
            end
          end else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
          end
        end
        if (rd) begin
          m_rdpos++;
          if (m_rdpos == FL) begin
            m_rdpos = 0;
            m_full--;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("in_ready", 32'(bus.in_ready), 32'(m_full < 2));
      check("out_valid", 32'(bus.out_valid), 32'(m_full > 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef REORDER_DROP_CNT_EN
      check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_bit", 32'(bus.out_bit), 32'(exp_q[0].b));
          check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_last_idle", 32'(bus.out_last), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic ab, input logic rdy, input logic r);
    @(negedge clk);
    rst             = r;
    bus.bit_valid   = v;
    bus.decoded_bit = b;
    bus.frame_abort = ab;
    bus.out_ready   = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [63:0] pat;
    rst             = 1'b1;
    bus.bit_valid   = 1'b0;
    bus.decoded_bit = 1'b0;
    bus.frame_abort = 1'b0;
    bus.out_ready   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_out_bit", 32'(bus.out_bit), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Alternating pattern with consumer always ready.
    for (int i = 0; i < FL; i++) drive(1'b1, 1'(i), 1'b0, 1'b1, 1'b0);
    idle(70, 1'b1);

    // Two full banks plus one extra bit that must be dropped.
    for (int i = 0; i < 2 * FL + 1; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("overflow_sticky", 32'(bus.overflow), 32'd1);
    idle(140, 1'b1);

    // Stall-toggled drain.
    for (int i = 0; i < FL; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 140; i++) drive(1'b0, 1'b0, 1'b0, 1'(i % 2 == 0), 1'b0);

    // Abort after 30 bits, with a bit_valid on the abort cycle that must be ignored.
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pat = 64'hFFFF_FFFF_0000_0000;
    for (int i = 0; i < FL; i++) drive(1'b1, pat[i], 1'b0, 1'b1, 1'b0);
    idle(70, 1'b1);

    // Reset while the first frame drains and the second is 40 bits in.
    for (int i = 0; i < FL; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < FL; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    idle(70, 1'b1);

    // Randomised traffic with occasional aborts and consumer stalls.
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 2) != 0), 1'b0);
    end
    idle(300, 1'b1);
    check("final_out_valid", 32'(bus.out_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
